// File: rtl/ps2_host_tx_axis.sv
// PS/2 host-to-device transmitter: accepts command bytes on an AXI-Stream slave and
// clocks them out to the device with inhibit, start, data, parity and stop, then checks the ack.
module ps2_host_tx_axis #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       axis_aclk_i,
  input  logic       axis_aresetn_i,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  input  logic [7:0] s_axis_tdata_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int CNT_MAX      = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam int START_CYCLES = 16;

  typedef enum logic [2:0] {IDLE, INHIBIT, START, XFER, WAIT_IDLE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bitcnt, bitcnt_n;
  logic [7:0]       data_r;
  logic             par_r;
  logic             nack, nack_n;
  logic             done_n, err_n;
  logic             clk_s1, clk_s2, clk_s3;
  logic             data_s1, data_s2;
  logic             fe, accept, timeout, tx_low;

  // Sync flops idle high so leaving reset never fakes a falling edge.
  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_i;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_i;
      data_s2 <= data_s1;
    end
  end

  assign fe = clk_s3 & ~clk_s2;

  // Handshake: a byte transfers on any rising clock edge where tvalid and tready are both 1;
  // tready is high only in IDLE, so the master holds its byte for the whole transmission.
  assign s_axis_tready_o = axis_aresetn_i & (state == IDLE);
  assign accept          = s_axis_tvalid_i & s_axis_tready_o;
  assign busy_o          = (state != IDLE);
  assign timeout         = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // bitcnt 0 is the start bit; data line is driven low for every 0 bit.
  always_comb begin
    tx_low = 1'b0;
    case (bitcnt)
      4'd0:                                            tx_low = 1'b1;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: tx_low = ~data_r[3'(bitcnt - 4'd1)];
      4'd9:                                            tx_low = ~par_r;
      default:                                         tx_low = 1'b0;
    endcase
  end

  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      nack   <= 1'b0;
      data_r <= '0;
      par_r  <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      nack   <= nack_n;
      done_o <= done_n;
      err_o  <= err_n;
      if (accept) begin
        data_r <= s_axis_tdata_i;
        par_r  <= ~^s_axis_tdata_i;
      end
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    bitcnt_n      = bitcnt;
    nack_n        = nack;
    done_n        = 1'b0;
    err_n         = 1'b0;
    ps2_clk_oe_o  = 1'b0;
    ps2_data_oe_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = INHIBIT;
          cnt_n   = '0;
          nack_n  = 1'b0;
        end
      end
      INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_n = START;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      START: begin
        ps2_clk_oe_o  = 1'b1;
        ps2_data_oe_o = 1'b1;
        if (cnt == CNT_W'(START_CYCLES - 1)) begin
          state_n  = XFER;
          cnt_n    = '0;
          bitcnt_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      XFER: begin
        ps2_data_oe_o = tx_low;
        if (fe) begin
          cnt_n = '0;
          // The eleventh falling edge carries the device ack on the data line.
          if (bitcnt == 4'd10) begin
            nack_n  = data_s2;
            state_n = WAIT_IDLE;
          end else begin
            bitcnt_n = bitcnt + 4'd1;
          end
        end else if (timeout) begin
          ps2_data_oe_o = 1'b0;
          state_n       = IDLE;
          done_n        = 1'b1;
          err_n         = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = nack;
        end else if (fe) begin
          cnt_n = '0;
        end else if (timeout) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx_axis.sv
// Bench for ps2_host_tx_axis: a PS/2 device model clocks frames out of the host and a
// monitor compares every done/err pulse and received frame against an expected queue.
module tb_ps2_host_tx_axis;

  localparam int INH  = 20;
  localparam int TMO  = 3000;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       ps2_clk, ps2_data;
  logic       clk_oe, data_oe;
  logic       busy, done, err;
  logic       dev_clk_low, dev_data_low;

  int checks = 0;
  int errors = 0;
  int dev_mode = 0;
  logic reached4 = 1'b0;

  // Expected entry: {err, has_frame, frame[10:0]}, frame = {stop, par, d7..d0, start}.
  logic [12:0] exp_q[$];
  logic [10:0] rx_q[$];

  always #5 clk = ~clk;

  // Open-drain bus with pull-ups.
  assign ps2_clk  = ~(clk_oe | dev_clk_low);
  assign ps2_data = ~(data_oe | dev_data_low);

  ps2_host_tx_axis #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .axis_aclk_i    (clk),
    .axis_aresetn_i (rst_n),
    .s_axis_tvalid_i(tvalid),
    .s_axis_tready_o(tready),
    .s_axis_tdata_i (tdata),
    .ps2_clk_i      (ps2_clk),
    .ps2_data_i     (ps2_data),
    .ps2_clk_oe_o   (clk_oe),
    .ps2_data_oe_o  (data_oe),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // sel 0: data_oe high, 1: clk_oe low, 2: done high. Counts negedges until true.
  task automatic count_until(input int sel, input int limit, output int k);
    k = 0;
    while (k < limit && !((sel == 0 && data_oe === 1'b1) ||
                          (sel == 1 && clk_oe === 1'b0) ||
                          (sel == 2 && done === 1'b1))) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) fail_now($sformatf("count_until_%0d", sel));
  endtask

  task automatic wait_done();
    int k;
    count_until(2, 6000, k);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = b;
    while (tready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (tready !== 1'b1) begin
      fail_now("accept_timeout");
      tvalid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      tvalid = 1'b0;
    end
  endtask

  // Device model: mode 0 ack, 1 nack, 2 never clocks, 3 stalls after the fourth falling edge.
  initial begin : device
    logic [10:0] frame;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && clk_oe === 1'b1 && data_oe === 1'b1) begin
        while (clk_oe === 1'b1) @(negedge clk);
        if (dev_mode != 2 && rst_n === 1'b1) begin
          frame = '0;
          repeat (HALF / 2) @(negedge clk);
          frame[0] = ps2_data;
          for (int i = 1; i <= 11; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (dev_mode == 3 && i == 4) begin
              reached4 = 1'b1;
              while (rst_n === 1'b1) @(negedge clk);
              while (rst_n === 1'b0) @(negedge clk);
              dev_clk_low = 1'b0;
              reached4    = 1'b0;
              break;
            end
            dev_clk_low = 1'b0;
            if (i <= 10) frame[i] = ps2_data;
            if (i == 10) begin
              rx_q.push_back(frame);
              repeat (HALF / 2) @(negedge clk);
              if (dev_mode == 0) dev_data_low = 1'b1;
              repeat (HALF / 2) @(negedge clk);
            end else if (i == 11) begin
              repeat (20) @(negedge clk);
              dev_data_low = 1'b0;
            end else begin
              repeat (HALF) @(negedge clk);
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (err === 1'b1 && done !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL err_without_done: err_o=1 done_o=%0b (t=%0t)", done, $time);
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done_o=1 err_o=%0b with nothing outstanding (t=%0t)", err, $time);
        end else begin
          e = exp_q.pop_front();
          check("done_err", err, e[12]);
          check("done_clk_oe", clk_oe, 0);
          check("done_data_oe", data_oe, 0);
          if (e[11]) begin
            if (rx_q.size() == 0) fail_now("frame_missing");
            else check("frame", rx_q.pop_front(), e[10:0]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int  k;
    int  n;
    logic seen;
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_busy", busy, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_reset", tready, 1);

    // 0xED with ack, plus phase timing.
    dev_mode = 0;
    exp_q.push_back({1'b0, 1'b1, 11'h7DA});
    send_byte(8'hED);
    check("accept_busy", busy, 1);
    check("accept_tready", tready, 0);
    check("accept_clk_oe", clk_oe, 1);
    check("accept_data_oe", data_oe, 0);
    count_until(0, 1000, k);
    check("inhibit_len", k, INH);
    count_until(1, 1000, k);
    check("start_len", k, 16);
    check("start_bit_held", data_oe, 1);
    wait_done();
    @(negedge clk);
    check("tready_after_done", tready, 1);

    // Parity cases.
    exp_q.push_back({1'b0, 1'b1, 11'h402});
    send_byte(8'h01);
    wait_done();
    exp_q.push_back({1'b0, 1'b1, 11'h7FE});
    send_byte(8'hFF);
    wait_done();

    // No ack.
    dev_mode = 1;
    exp_q.push_back({1'b1, 1'b1, 11'h6AA});
    send_byte(8'h55);
    wait_done();
    repeat (5) @(negedge clk);

    // No device clock: timeout measured from XFER entry.
    dev_mode = 2;
    exp_q.push_back({1'b1, 1'b0, 11'h000});
    send_byte(8'h12);
    count_until(0, 1000, k);
    count_until(1, 1000, k);
    count_until(2, 5000, k);
    check("timeout_len", k, TMO);
    repeat (5) @(negedge clk);

    // Reset after the fourth falling edge.
    dev_mode = 3;
    send_byte(8'hA5);
    n = 0;
    while (reached4 !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (reached4 !== 1'b1) fail_now("reached4");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_clk_oe", clk_oe, 0);
    check("midrst_data_oe", data_oe, 0);
    check("midrst_done", done, 0);
    check("midrst_tready", tready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_tready_after", tready, 1);
    repeat (300) @(negedge clk);

    // Back-to-back: 0x02 must wait for the first done.
    dev_mode = 0;
    exp_q.push_back({1'b0, 1'b1, 11'h7DA});
    exp_q.push_back({1'b0, 1'b1, 11'h404});
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = 8'hED;
    n = 0;
    while (tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    tdata = 8'h02;
    seen  = 1'b0;
    n     = 0;
    while (tready !== 1'b1 && n < 6000) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    if (done === 1'b1) seen = 1'b1;
    if (tready !== 1'b1) fail_now("b2b_second_accept");
    else check("b2b_after_done", seen, 1);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    wait_done();

    repeat (50) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
